// File: rtl/iir_pkg.sv
// Shared types and constants for the iir frame sequencer: sample format,
// controller states and the fixed geometry of buffers and filter timing.
package iir_pkg;
  localparam int W       = 11;
  localparam int MAX_LEN = 128;
  localparam int IIR_LAT = 1;
  localparam int CLR_CYC = 2;

  typedef logic signed [W-1:0] sample_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CLR   = 3'd2,
    RUN   = 3'd3,
    DRAIN = 3'd4,
    DONE  = 3'd5
  } ctrl_state_t;

  localparam sample_t IMPULSE_VAL = 11'b01111111111;

  // Requested lengths above the buffer depth are clipped to a full buffer.
  function automatic logic [7:0] sat_len(input logic [7:0] len);
    return (len > 8'(MAX_LEN)) ? 8'(MAX_LEN) : len;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO: rd_data always shows the oldest entry while not empty.
// A push on a full FIFO is accepted only together with a pop.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             wr_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             rd_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end
endmodule

// File: rtl/iir_frame_ctrl.sv
// Frame sequencer around a free-running iir filter: load a frame, clear the filter,
// burst the samples back-to-back and queue the filter responses for a consumer.
module iir_frame_ctrl
  import iir_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         impulse_mode,
  input  logic [7:0]   frame_len,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready,
  output logic         busy,
  output logic         done,
  output logic         iir_rst,
  output logic [W-1:0] iir_x,
  input  logic [W-1:0] iir_z,
  output logic [2:0]   dbg_state
);
  localparam int CCW = $clog2(CLR_CYC) + 1;

  // Both data ports transfer a word on a rising edge where valid && ready; valid must
  // not depend on ready, and out_data stays stable while out_valid is high and unpopped.
  ctrl_state_t      state, state_nxt;
  logic [7:0]       len, len_nxt;
  logic [7:0]       cnt, cnt_nxt;
  logic [7:0]       in_count, loaded_nxt;
  logic             imp;
  logic [CCW-1:0]   clr_cnt;
  logic [IIR_LAT-1:0] lat_sr, lat_nxt;
  logic             issue, in_push, in_pop, out_push, out_pop, out_empty;
  logic [W-1:0]     in_head, x_nxt;
  logic             unused_flags;
  logic             in_full, in_empty, out_full;
  logic [7:0]       out_count;

  assign in_push    = in_valid && in_ready;
  assign in_pop     = issue && !imp;
  assign out_push   = lat_sr[IIR_LAT-1];
  assign out_valid  = !out_empty;
  assign out_pop    = out_valid && out_ready;
  assign loaded_nxt = in_count + {7'd0, in_push};
  assign dbg_state  = state;
  assign unused_flags = &{1'b0, in_full, in_empty, out_full, out_count};

  always_comb begin
    state_nxt = state;
    len_nxt   = len;
    cnt_nxt   = cnt;
    issue     = 1'b0;
    lat_nxt   = (lat_sr << 1) | IIR_LAT'(state == RUN);
    case (state)
      IDLE: if (start) begin
        len_nxt = sat_len(frame_len);
        cnt_nxt = '0;
        if (frame_len == 8'd0)  state_nxt = DONE;
        else if (impulse_mode)  state_nxt = CLR;
        else                    state_nxt = LOAD;
      end
      LOAD:  if (in_push && (loaded_nxt == len)) state_nxt = CLR;
      // The output queue must be empty before a burst so it can absorb a full frame.
      CLR: if ((clr_cnt == CCW'(CLR_CYC - 1)) && out_empty) begin
        state_nxt = RUN;
        issue     = 1'b1;
        cnt_nxt   = 8'd1;
      end
      RUN: if (cnt == len) state_nxt = DRAIN;
           else begin
             issue   = 1'b1;
             cnt_nxt = cnt + 8'd1;
           end
      DRAIN:   if (lat_nxt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    x_nxt = '0;
    if (issue) x_nxt = imp ? ((state == CLR) ? IMPULSE_VAL : '0) : in_head;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      len      <= '0;
      cnt      <= '0;
      imp      <= 1'b0;
      clr_cnt  <= '0;
      lat_sr   <= '0;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      iir_rst  <= 1'b1;
      iir_x    <= '0;
    end else begin
      state    <= state_nxt;
      len      <= len_nxt;
      cnt      <= cnt_nxt;
      if (state == IDLE && start) imp <= impulse_mode;
      if (state != CLR)                         clr_cnt <= '0;
      else if (clr_cnt != CCW'(CLR_CYC - 1))    clr_cnt <= clr_cnt + 1'b1;
      lat_sr   <= lat_nxt;
      in_ready <= (state_nxt == LOAD) && (loaded_nxt < len_nxt);
      busy     <= (state_nxt != IDLE);
      done     <= (state_nxt == DONE);
      iir_rst  <= (state_nxt == CLR);
      iir_x    <= x_nxt;
    end
  end

  sync_fifo #(.WIDTH(W), .DEPTH(MAX_LEN)) u_in_buf (
    .clk(clk), .rst(rst), .push(in_push), .wr_data(in_data), .pop(in_pop),
    .rd_data(in_head), .full(in_full), .empty(in_empty), .count(in_count)
  );

  sync_fifo #(.WIDTH(W), .DEPTH(MAX_LEN)) u_out_buf (
    .clk(clk), .rst(rst), .push(out_push), .wr_data(iir_z), .pop(out_pop),
    .rd_data(out_data), .full(out_full), .empty(out_empty), .count(out_count)
  );
endmodule

// File: tb/tb_iir_frame_ctrl.sv
// Bench for iir_frame_ctrl with a behavioural one-pole filter y = x + y/2 (latency 1,
// saturating to 11 bits); expected outputs are queued at start and popped by a monitor.
module tb_iir_frame_ctrl;
  import iir_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         impulse_mode = 1'b0;
  logic [7:0]   frame_len = 8'd0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         out_ready = 1'b0;
  logic         in_ready, out_valid, busy, done, iir_rst;
  logic [W-1:0] out_data, iir_x, iir_z;
  logic [2:0]   dbg_state;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  int vec[MAX_LEN];
  int done_cnt = 0, in_ready_cnt = 0, rst_len = 0, last_rst_len = 0, bursts = 0;
  logic signed [W-1:0] z_reg = '0;

  always #5 clk = ~clk;

  iir_frame_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .impulse_mode(impulse_mode),
    .frame_len(frame_len), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .busy(busy),
    .done(done), .iir_rst(iir_rst), .iir_x(iir_x), .iir_z(iir_z), .dbg_state(dbg_state)
  );

  function automatic int sat11(input int v);
    if (v > 1023) return 1023;
    if (v < -1024) return -1024;
    return v;
  endfunction

  always @(posedge clk) begin
    if (iir_rst) z_reg <= '0;
    else         z_reg <= W'(sat11(int'($signed(iir_x)) + (int'(z_reg) >>> 1)));
  end
  assign iir_z = z_reg;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic monitor();
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (done) done_cnt++;
      if (in_ready) in_ready_cnt++;
      if (iir_rst) rst_len++;
      else begin
        if (rst_len > 0 && busy) begin
          last_rst_len = rst_len;
          bursts++;
        end
        rst_len = 0;
      end
      if (rst && out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL out_unexpected: got %0d, no output expected", $signed(out_data));
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e) begin
            errors++;
            $display("FAIL out_data: got %0d, expected %0d", $signed(out_data), $signed(e));
          end
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Impulse response: 1023, 511, 255, 127, 63, 31, 15, 7, 3, 1, 0, ...
  task automatic push_expected(input int n, input bit imp);
    int y = 0;
    int x;
    for (int k = 0; k < n; k++) begin
      x = imp ? ((k == 0) ? 1023 : 0) : vec[k];
      y = sat11(x + (y >>> 1));
      exp_q.push_back(W'(y));
    end
  endtask

  task automatic start_frame(input int len, input bit imp);
    start = 1'b1;
    impulse_mode = imp;
    frame_len = 8'(len);
    tick();
    start = 1'b0;
    impulse_mode = 1'b0;
    push_expected((len > MAX_LEN) ? MAX_LEN : len, imp);
  endtask

  task automatic load_frame(input int n, input bit gaps);
    int i = 0;
    int t = 0;
    bit acc;
    while (i < n && t < 1000) begin
      in_valid = !gaps || (t % 2 == 0);
      in_data  = W'(vec[i]);
      @(negedge clk);
      acc = in_valid && in_ready;
      tick();
      t++;
      if (acc) begin
        i++;
        if (gaps) check("in_ready_after_accept", int'(in_ready), int'(i < n));
      end
    end
    in_valid = 1'b0;
    check("load_complete", i, n);
  endtask

  task automatic wait_done(input int d0, input int budget, input string name);
    int t = 0;
    while (done_cnt == d0 && t < budget) begin
      tick();
      t++;
    end
    check({"done_seen_", name}, int'(done_cnt > d0), 1);
  endtask

  task automatic wait_drain(input int budget, input string name);
    int t = 0;
    while ((exp_q.size() != 0 || out_valid) && t < budget) begin
      tick();
      t++;
    end
    check({"drained_", name}, exp_q.size(), 0);
  endtask

  initial begin
    int d0, r0, b0, k, t;
    fork
      monitor();
    join_none

    #1 rst = 1'b0;
    #1;
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_iir_rst", int'(iir_rst), 1);
    check("rst_iir_x", int'(iir_x), 0);
    check("rst_state", int'(dbg_state), 0);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check("idle_iir_rst", int'(iir_rst), 0);

    // 1: impulse frame of 100 with a start pulse while busy that must be ignored
    out_ready = 1'b1;
    d0 = done_cnt;
    r0 = in_ready_cnt;
    start_frame(100, 1'b1);
    repeat (10) tick();
    check("s1_busy_mid", int'(busy), 1);
    start = 1'b1; impulse_mode = 1'b1; frame_len = 8'd5;
    tick();
    start = 1'b0; impulse_mode = 1'b0;
    wait_done(d0, 400, "s1");
    repeat (3) tick();
    check("s1_done_pulses", done_cnt - d0, 1);
    check("s1_in_ready_never", in_ready_cnt - r0, 0);
    wait_drain(300, "s1");
    check("s1_clr_len", last_rst_len, 2);

    // 2: four loaded samples with valid gaps; expected 100, -150, 225, -288
    vec[0] = 100; vec[1] = -200; vec[2] = 300; vec[3] = -400;
    d0 = done_cnt;
    start_frame(4, 1'b0);
    load_frame(4, 1'b1);
    k = 0; t = 0;
    @(negedge clk);
    while (iir_rst && t < 20) begin
      k++;
      t++;
      @(negedge clk);
    end
    check("s2_clr_cycles", k, 2);
    check("s2_x0", int'($signed(iir_x)), vec[0]);
    for (int j = 1; j < 4; j++) begin
      @(negedge clk);
      check("s2_x_burst", int'($signed(iir_x)), vec[j]);
    end
    @(negedge clk);
    check("s2_x_after", int'($signed(iir_x)), 0);
    tick();
    wait_done(d0, 100, "s2");
    wait_drain(100, "s2");

    // 3: full frame held by a stalled consumer; next impulse frame waits in CLR
    out_ready = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) vec[i] = ((i * 37) % 512) - 256;
    d0 = done_cnt;
    start_frame(128, 1'b0);
    load_frame(128, 1'b0);
    wait_done(d0, 600, "s3a");
    tick();
    check("s3_out_valid_held", int'(out_valid), 1);
    d0 = done_cnt;
    start_frame(3, 1'b1);
    repeat (20) tick();
    check("s3_wait_in_clr", int'(dbg_state), int'(CLR));
    check("s3_iir_rst_hold", int'(iir_rst), 1);
    check("s3_no_loss", exp_q.size(), 131);
    out_ready = 1'b1;
    wait_done(d0, 600, "s3b");
    wait_drain(100, "s3");

    // 4: zero-length frame goes straight to DONE with no outputs
    d0 = done_cnt;
    start_frame(0, 1'b0);
    check("s4_done_high", int'(done), 1);
    check("s4_busy_high", int'(busy), 1);
    tick();
    check("s4_done_low", int'(done), 0);
    check("s4_busy_low", int'(busy), 0);
    repeat (5) tick();
    check("s4_done_pulses", done_cnt - d0, 1);
    check("s4_no_output", int'(out_valid), 0);

    // 5: reset mid-burst, then a fresh impulse frame
    start_frame(100, 1'b1);
    t = 0;
    while (dbg_state != 3'(RUN) && t < 50) begin
      tick();
      t++;
    end
    repeat (50) tick();
    check("s5_in_run", int'(dbg_state), int'(RUN));
    #2 rst = 1'b0;
    #1;
    check("s5_in_ready", int'(in_ready), 0);
    check("s5_out_valid", int'(out_valid), 0);
    check("s5_iir_rst", int'(iir_rst), 1);
    check("s5_busy", int'(busy), 0);
    check("s5_iir_x", int'(iir_x), 0);
    exp_q.delete();
    repeat (2) tick();
    rst = 1'b1;
    tick();
    d0 = done_cnt;
    start_frame(100, 1'b1);
    wait_done(d0, 400, "s5");
    wait_drain(300, "s5");

    // 6: back-to-back impulse frames give identical responses
    b0 = bursts;
    d0 = done_cnt;
    start_frame(12, 1'b1);
    wait_done(d0, 100, "s6a");
    d0 = done_cnt;
    start_frame(12, 1'b1);
    wait_done(d0, 100, "s6b");
    wait_drain(100, "s6");
    check("s6_bursts", bursts - b0, 2);
    check("s6_clr_len", last_rst_len, 2);

    // 7: oversize length clips to a full buffer of 128 outputs
    d0 = done_cnt;
    start_frame(200, 1'b1);
    wait_done(d0, 400, "s7");
    wait_drain(300, "s7");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
